// File: rtl/word_merger.sv
// word_merger: collects a byte-serial stream into 32-bit words.
// Four accepted bytes become one word. The order of the bytes in the word is
// set by MSB_FIRST. The output register can drain while the next word is filling.
// Only the byte that would complete a word is held back by a stalled consumer.

`timescale 1ns/1ps

module word_merger #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  byte_cnt
);

    logic [1:0]  byteCnt_q, byteCnt_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] outWord_q, outWord_d;
    logic        outValid_q, outValid_d;

    logic [1:0]  lane;
    logic [31:0] merged;
    logic        byteXfer;
    logic        wordXfer;
    logic        wordDone;

    // The 4th byte may enter only if the output register is empty or draining this cycle.
    always_comb begin
        in_ready = (byteCnt_q != 2'd3) | ~outValid_q | out_ready;
    end

    // Decode the handshakes. A byte that arrives together with clr is dropped.
    always_comb begin
        byteXfer = in_valid & in_ready & ~clr;
        wordXfer = outValid_q & out_ready;
        wordDone = byteXfer & (byteCnt_q == 2'd3);
    end

    // Put the incoming byte into the lane for its position in the word.
    always_comb begin
        lane   = MSB_FIRST ? (2'd3 - byteCnt_q) : byteCnt_q;
        merged = acc_q;
        merged[lane*8 +: 8] = in_byte;
    end

    // Next-state logic for the byte count, the accumulator and the output register.
    always_comb begin
        byteCnt_d  = byteCnt_q;
        acc_d      = acc_q;
        outWord_d  = outWord_q;
        outValid_d = outValid_q;

        if (wordXfer) begin
            outValid_d = 1'b0;
        end

        if (clr) begin
            byteCnt_d = 2'd0;
            acc_d     = 32'h0;
        end else if (byteXfer) begin
            byteCnt_d = byteCnt_q + 2'd1;
            acc_d     = merged;
            if (wordDone) begin
                outWord_d  = merged;
                outValid_d = 1'b1;
            end
        end
    end

    // State registers. Reset clears them immediately, without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byteCnt_q  <= 2'd0;
            acc_q      <= 32'h0;
            outWord_q  <= 32'h0;
            outValid_q <= 1'b0;
        end else begin
            byteCnt_q  <= byteCnt_d;
            acc_q      <= acc_d;
            outWord_q  <= outWord_d;
            outValid_q <= outValid_d;
        end
    end

    // Drive the outputs directly from the registers.
    always_comb begin
        out_word  = outWord_q;
        out_valid = outValid_q;
        byte_cnt  = byteCnt_q;
    end

endmodule

// File: tb/tb_word_merger.sv
// tb_word_merger: directed test for word_merger.
// One instance is built with each byte order, and both receive the same stimulus.

`timescale 1ns/1ps

module tb_word_merger;

    logic        clk;
    logic        rstN;
    logic        clr;
    logic [7:0]  inByte;
    logic        inValid;
    logic        outReady;

    logic        inReadyM, outValidM;
    logic [31:0] outWordM;
    logic [1:0]  byteCntM;
    logic        inReadyL, outValidL;
    logic [31:0] outWordL;
    logic [1:0]  byteCntL;

    int errorCount = 0;
    int checkCount = 0;

    logic [31:0] expM, expL;
    logic [7:0]  b;

    word_merger #(.MSB_FIRST(1'b1)) dutMsb (
        .clk(clk), .rst_n(rstN), .clr(clr),
        .in_byte(inByte), .in_valid(inValid), .in_ready(inReadyM),
        .out_word(outWordM), .out_valid(outValidM), .out_ready(outReady),
        .byte_cnt(byteCntM)
    );

    word_merger #(.MSB_FIRST(1'b0)) dutLsb (
        .clk(clk), .rst_n(rstN), .clr(clr),
        .in_byte(inByte), .in_valid(inValid), .in_ready(inReadyL),
        .out_word(outWordL), .out_valid(outValidL), .out_ready(outReady),
        .byte_cnt(byteCntL)
    );

    // Free-running clock with a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison, and report it if observed and expected differ.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one input cycle, then wait 1 ns after the next rising edge before returning.
    task automatic applyStimulus(input logic [7:0] data, input logic valid);
        inByte  = data;
        inValid = valid;
        @(posedge clk);
        #1;
    endtask

    // Check the word output of both instances.
    task automatic checkWord(input string tag, input logic [31:0] wm, input logic [31:0] wl);
        checkOutput({tag, "_msb"}, outWordM, wm);
        checkOutput({tag, "_lsb"}, outWordL, wl);
    endtask

    initial begin
        rstN     = 1'b0;
        clr      = 1'b0;
        inByte   = 8'h00;
        inValid  = 1'b0;
        outReady = 1'b0;

        // Reset values, checked with no clock edge yet.
        #3;
        checkOutput("rst_valid", {31'b0, outValidM}, 32'd0);
        checkOutput("rst_word",  outWordM, 32'h0);
        checkOutput("rst_cnt",   {30'b0, byteCntM}, 32'd0);
        checkOutput("rst_ready", {31'b0, inReadyM}, 32'd1);
        #5;
        rstN = 1'b1;
        @(posedge clk);
        #1;

        // Four back-to-back bytes. Each byte order should give its own word.
        outReady = 1'b1;
        applyStimulus(8'h12, 1'b1);
        checkOutput("first_cnt", {30'b0, byteCntM}, 32'd1);
        applyStimulus(8'h34, 1'b1);
        applyStimulus(8'h56, 1'b1);
        applyStimulus(8'h78, 1'b1);
        checkOutput("w1_valid", {31'b0, outValidM}, 32'd1);
        checkOutput("w1_validL", {31'b0, outValidL}, 32'd1);
        checkWord("w1", 32'h12345678, 32'h78563412);
        checkOutput("w1_cnt", {30'b0, byteCntM}, 32'd0);
        applyStimulus(8'h00, 1'b0);
        checkOutput("w1_drain", {31'b0, outValidM}, 32'd0);
        checkWord("w1_keep", 32'h12345678, 32'h78563412);

        // Stall the consumer. Bytes 5 to 7 are still accepted, but byte 8 waits.
        outReady = 1'b0;
        for (int i = 1; i <= 4; i++) applyStimulus(8'(i), 1'b1);
        checkOutput("bp_valid", {31'b0, outValidM}, 32'd1);
        checkWord("bp_w1", 32'h01020304, 32'h04030201);
        for (int i = 5; i <= 7; i++) begin
            applyStimulus(8'(i), 1'b1);
            checkOutput("bp_cnt", {30'b0, byteCntM}, 32'(i - 4));
            checkWord("bp_hold", 32'h01020304, 32'h04030201);
        end
        inByte = 8'h08;
        #1;
        checkOutput("bp_notready", {31'b0, inReadyM}, 32'd0);
        applyStimulus(8'h08, 1'b1);
        checkOutput("bp_cnt3", {30'b0, byteCntM}, 32'd3);
        checkWord("bp_stable", 32'h01020304, 32'h04030201);
        outReady = 1'b1;
        #1;
        checkOutput("bp_ready", {31'b0, inReadyM}, 32'd1);
        applyStimulus(8'h08, 1'b1);
        checkOutput("bp_w2_valid", {31'b0, outValidM}, 32'd1);
        checkWord("bp_w2", 32'h05060708, 32'h08070605);
        applyStimulus(8'h00, 1'b0);
        checkOutput("bp_drain", {31'b0, outValidM}, 32'd0);

        // A steady stream of 12 bytes with the consumer always ready.
        expM = 32'h0;
        expL = 32'h0;
        for (int i = 0; i < 12; i++) begin
            b = 8'hA0 + 8'(i);
            expM = {expM[23:0], b};
            expL = {b, expL[31:8]};
            inByte  = b;
            inValid = 1'b1;
            #1;
            checkOutput("st_ready", {31'b0, inReadyM}, 32'd1);
            applyStimulus(b, 1'b1);
            checkOutput("st_valid", {31'b0, outValidM}, {31'b0, (i % 4) == 3});
            if ((i % 4) == 3) checkWord("st_word", expM, expL);
        end
        applyStimulus(8'h00, 1'b0);

        // clr throws away a partial word, and drops the byte it arrives with.
        applyStimulus(8'hAA, 1'b1);
        applyStimulus(8'hBB, 1'b1);
        clr = 1'b1;
        applyStimulus(8'hCC, 1'b1);
        clr = 1'b0;
        checkOutput("clr_cnt", {30'b0, byteCntM}, 32'd0);
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        applyStimulus(8'h33, 1'b1);
        applyStimulus(8'h44, 1'b1);
        checkWord("clr_word", 32'h11223344, 32'h44332211);
        applyStimulus(8'h00, 1'b0);

        // Assert reset with no clock edge while a word is pending and 3 bytes are held.
        outReady = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(8'hC1 + 8'(i), 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(8'hD1 + 8'(i), 1'b1);
        checkOutput("ar_pre_cnt", {30'b0, byteCntM}, 32'd3);
        inValid = 1'b0;
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("ar_valid", {31'b0, outValidM}, 32'd0);
        checkWord("ar_word", 32'h0, 32'h0);
        checkOutput("ar_cnt", {30'b0, byteCntM}, 32'd0);
        checkOutput("ar_ready", {31'b0, inReadyM}, 32'd1);
        #2;
        rstN = 1'b1;
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(8'hE1 + 8'(i), 1'b1);
        checkOutput("ar_new_valid", {31'b0, outValidM}, 32'd1);
        checkWord("ar_new", 32'hE1E2E3E4, 32'hE4E3E2E1);
        applyStimulus(8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/word_merger.md
WORD_MERGER -- requirements
Module: word_merger

Interface
REQ-001 Parameter MSB_FIRST, default 1: byte order; 1 means the first accepted byte becomes word[31:24], 0 means it becomes word[7:0].
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 clr  input  1  synchronous abort of a partially assembled word.
REQ-005 in_byte  input  8  byte-serial data.
REQ-006 in_valid  input  1  in_byte is valid this cycle.
REQ-007 in_ready  output  1  block can accept in_byte this cycle.
REQ-008 out_word  output  32  assembled word; inverse of the four-byte split O1..O4 = A[31:24]..A[7:0].
REQ-009 out_valid  output  1  out_word holds a complete, unconsumed word.
REQ-010 out_ready  input  1  downstream accepts out_word this cycle.
REQ-011 byte_cnt  output  2  number of bytes held in the partial word (0-3).

Function
REQ-012 A byte transfer occurs on a rising edge with in_valid=1 and in_ready=1; a word transfer occurs on a rising edge with out_valid=1 and out_ready=1.
REQ-013 Accepted bytes are stored in a 32-bit accumulator at lane byte_cnt: MSB_FIRST=1 uses lanes [31:24],[23:16],[15:8],[7:0]; MSB_FIRST=0 uses the reverse order.
REQ-014 States: FILL (byte_cnt 0-3, output register empty or draining) and HOLD (byte_cnt=3, output register full and not draining); state is derived from byte_cnt and out_valid and needs no separate encoding.
REQ-015 in_ready = (byte_cnt != 3) | ~out_valid | out_ready; this is combinational, and in_ready never depends on in_valid.
REQ-016 On acceptance of the 4th byte, the full word (3 held bytes plus the current byte) loads into out_word, out_valid is 1 on the next cycle, and byte_cnt wraps 3 -> 0.
REQ-017 Latency: the 4th byte accepted at edge N gives out_valid=1 after edge N; a sustained throughput of 1 byte/cycle is maintained when out_ready=1.
REQ-018 Simultaneous word transfer and 4th-byte acceptance at the same edge: the new word replaces the old one and out_valid stays 1.
REQ-019 A word transfer with no new word completing clears out_valid to 0 at that edge; out_word keeps its last value.
REQ-020 While out_valid=1 and out_ready=0, out_word and out_valid are held stable.
REQ-021 Bytes 1-3 may be accepted while out_valid=1 (overlap); only the 4th byte is back-pressured.
REQ-022 clr=1 sets byte_cnt to 0 and discards the partial word; any byte presented in that cycle is dropped; out_valid and out_word are unaffected.
REQ-023 Unused accumulator lanes are don't-care internally and are never visible on out_word.

Reset
REQ-024 rst_n=0 immediately (without a clock) forces out_valid=0, out_word=32'h0, byte_cnt=0, and the accumulator to 0; in_ready reads 1 during reset.
REQ-025 Reset mid-word discards the partial bytes; after release the first accepted byte is treated as byte 0.
REQ-026 Release of rst_n has no effect until the first rising clk edge after release.

Verification
REQ-027 MSB_FIRST=1, out_ready=1, bytes 8'h12,8'h34,8'h56,8'h78 on 4 consecutive cycles -> out_word=32'h12345678 with out_valid=1 for exactly 1 cycle.
REQ-028 MSB_FIRST=0, same stimulus -> out_word=32'h78563412.
REQ-029 out_ready=0, stream of 8 bytes 01..08 -> word 32'h01020304 held; bytes 05-07 accepted; in_ready=0 at byte 08; out_ready=1 for one cycle -> word 32'h05060708 appears on the next edge with no byte lost.
REQ-030 Continuous 12-byte stream with out_ready=1 -> 3 words, in_ready stays 1 throughout, and consecutive words appear every 4 cycles.
REQ-031 2 bytes AA,BB, then clr=1, then 11,22,33,44 -> out_word=32'h11223344 and AA/BB never appear.
REQ-032 Assert rst_n=0 asynchronously after 3 bytes while out_valid=1 -> outputs clear within the same cycle; the next 4 bytes form a clean word.
